// File: rtl/div_sequencer.sv
// div_sequencer
//
// Sequences one DIV/DIVU/REM/REMU request between the control unit and an
// iterative unsigned divider. The two RISC-V special cases are answered
// directly, without the divider:
//   - divide-by-zero
//   - signed overflow (most negative value / -1)
// Every other request goes to the divider as unsigned magnitudes. The block
// pulses start_div, waits for div_ready, and then fixes up the signs of the
// quotient and remainder.
//
// Optional feature macro: DIV_TIMEOUT_EN
//   When defined, a watchdog aborts WAIT after TIMEOUT_CYCLES cycles without
//   div_ready. The response then carries rsp_error=1 and rsp_result=0.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   req_valid/req_ready         request handshake (ready only in IDLE)
//   req_op                      00 DIV, 01 DIVU, 10 REM, 11 REMU
//   req_a, req_b                dividend, divisor
//   start_div                   one-cycle start pulse to the divider
//   div_operand_a/_b            registered unsigned magnitudes for the divider
//   div_ready                   divider done
//   div_quotient/_remainder     unsigned divider results
//   rsp_valid/rsp_ready         response handshake
//   rsp_result, rsp_error       final result, watchdog abort flag
//   busy                        high whenever the sequencer is not IDLE
module div_sequencer #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             start_div,
  output logic [WIDTH-1:0] div_operand_a,
  output logic [WIDTH-1:0] div_operand_b,
  input  logic             div_ready,
  input  logic [WIDTH-1:0] div_quotient,
  input  logic [WIDTH-1:0] div_remainder,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_error,
  output logic             busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_FIXUP,
    ST_RESP
  } state_t;

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_reg, state_next;

  logic [1:0]       op_reg;
  logic             a_neg_reg;       // dividend negative (signed ops only)
  logic             b_neg_reg;       // divisor negative (signed ops only)
  logic [WIDTH-1:0] operand_a_reg;
  logic [WIDTH-1:0] operand_b_reg;
  logic [WIDTH-1:0] quotient_reg;
  logic [WIDTH-1:0] remainder_reg;
  logic [WIDTH-1:0] result_reg;

  // Request decode, only meaningful in the accept cycle.
  logic             req_signed;
  logic             req_a_neg;
  logic             req_b_neg;
  logic             div_by_zero;
  logic             signed_ovf;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;

  assign req_signed  = ~req_op[0];
  assign req_a_neg   = req_signed & req_a[WIDTH-1];
  assign req_b_neg   = req_signed & req_b[WIDTH-1];
  assign div_by_zero = (req_b == '0);
  assign signed_ovf  = req_signed && (req_a == MIN_NEG) && (req_b == '1);
  // Negating MIN_NEG wraps to itself, which is still the correct unsigned
  // magnitude.
  assign mag_a       = req_a_neg ? (~req_a + 1'b1) : req_a;
  assign mag_b       = req_b_neg ? (~req_b + 1'b1) : req_b;

  // Sign fix-up for the captured divider results.
  logic [WIDTH-1:0] fixed_quotient;
  logic [WIDTH-1:0] fixed_remainder;

  assign fixed_quotient  = (a_neg_reg ^ b_neg_reg) ? (~quotient_reg + 1'b1)
                                                   : quotient_reg;
  assign fixed_remainder = a_neg_reg ? (~remainder_reg + 1'b1) : remainder_reg;

`ifdef DIV_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] timeout_cnt_reg;
  logic             error_reg;
  logic             timeout_hit;

  // The cycle that would complete TIMEOUT_CYCLES idle WAIT cycles.
  assign timeout_hit = (timeout_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
  assign rsp_error   = error_reg;
`else
  assign rsp_error   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    start_div  = 1'b0;
    rsp_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
        if (req_valid) begin
          state_next = (div_by_zero || signed_ovf) ? ST_RESP : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        start_div  = 1'b1;
        state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (div_ready) begin
          state_next = ST_FIXUP;
        end
`ifdef DIV_TIMEOUT_EN
        else if (timeout_hit) begin
          state_next = ST_RESP;
        end
`endif
      end
      ST_FIXUP: begin
        state_next = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_reg        <= '0;
      a_neg_reg     <= 1'b0;
      b_neg_reg     <= 1'b0;
      operand_a_reg <= '0;
      operand_b_reg <= '0;
      quotient_reg  <= '0;
      remainder_reg <= '0;
      result_reg    <= '0;
`ifdef DIV_TIMEOUT_EN
      timeout_cnt_reg <= '0;
      error_reg       <= 1'b0;
`endif
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req_valid) begin
            op_reg    <= req_op;
            a_neg_reg <= req_a_neg;
            b_neg_reg <= req_b_neg;
`ifdef DIV_TIMEOUT_EN
            error_reg <= 1'b0;
`endif
            if (div_by_zero) begin
              result_reg <= req_op[1] ? req_a : '1;
            end else if (signed_ovf) begin
              result_reg <= req_op[1] ? '0 : MIN_NEG;
            end else begin
              operand_a_reg <= mag_a;
              operand_b_reg <= mag_b;
            end
          end
        end
        ST_ISSUE: begin
`ifdef DIV_TIMEOUT_EN
          timeout_cnt_reg <= '0;
`endif
        end
        ST_WAIT: begin
          if (div_ready) begin
            quotient_reg  <= div_quotient;
            remainder_reg <= div_remainder;
          end
`ifdef DIV_TIMEOUT_EN
          else if (timeout_hit) begin
            result_reg <= '0;
            error_reg  <= 1'b1;
          end else begin
            timeout_cnt_reg <= timeout_cnt_reg + 1'b1;
          end
`endif
        end
        ST_FIXUP: begin
          result_reg <= op_reg[1] ? fixed_remainder : fixed_quotient;
        end
        default: begin
        end
      endcase
    end
  end

  assign div_operand_a = operand_a_reg;
  assign div_operand_b = operand_b_reg;
  assign rsp_result    = result_reg;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle divide sequencer between the control unit and the ALU's iterative divider. It accepts a signed or unsigned DIV/DIVU/REM/REMU request and resolves RISC-V special cases (divide-by-zero, signed overflow) without using the divider. Otherwise it pulses `start_div` with unsigned operand magnitudes, waits for `div_ready`, then applies sign fix-up. It holds `busy` high so the control unit stalls in EXECUTE until the result is taken.

## Interface
- `WIDTH`, 32, operand/result width
- `TIMEOUT_CYCLES`, 64, watchdog limit in WAIT cycles; only used with `DIV_TIMEOUT_EN`
- `clk`  in  1  clock; single clock domain
- `reset`  in  1  synchronous, active-high reset
- `req_valid`  in  1  divide request
- `req_ready`  out  1  high only in IDLE
- `req_op`  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- `req_a`, `req_b`  in  WIDTH  dividend, divisor
- `start_div`  out  1  one-cycle pulse to divider
- `div_operand_a`, `div_operand_b`  out  WIDTH  unsigned magnitudes, registered, stable from ISSUE until leaving WAIT
- `div_ready`  in  1  divider done
- `div_quotient`, `div_remainder`  in  WIDTH  unsigned divider results
- `rsp_valid`  out  1  result valid
- `rsp_ready`  in  1  consumer accepts
- `rsp_result`  out  WIDTH  final quotient or remainder
- `rsp_error`  out  1  watchdog abort
- `busy`  out  1  state != IDLE

## Operation
- States: IDLE, ISSUE, WAIT, FIXUP, RESP.
- **IDLE:** `req_ready`=1. The accept cycle T is the cycle with `req_valid`&&`req_ready`. The block latches op, operands and signs.
  - Divisor == 0: result = all-ones for DIV/DIVU, dividend for REM/REMU. Next state RESP.
  - Signed op with dividend == 0x80000000 and divisor == 0xFFFFFFFF: result = 0x80000000 for DIV, 0 for REM. Next state RESP.
  - Otherwise: next state ISSUE. Operand magnitudes are two's-complement absolute values for signed ops and raw values for unsigned ops.
- **ISSUE:** `start_div`=1 for exactly this one cycle. Next state WAIT. `div_ready` is ignored in ISSUE.
- **WAIT:** `div_ready` is sampled every cycle. On `div_ready`, the block captures quotient and remainder and moves to FIXUP.
- **FIXUP:** signed ops only:
  - quotient is negated iff the operand signs differ;
  - remainder is negated iff the dividend is negative.
  - Result is selected by op[1]. Next state RESP.
- **RESP:** `rsp_valid`=1. `rsp_result` and `rsp_error` are held stable until `rsp_ready`. On handshake, next state IDLE.
- All arithmetic is modulo 2^WIDTH. Negating 0x80000000 yields 0x80000000; this is legal as an unsigned magnitude.

## Timing
- Reset (synchronous): state IDLE.
  - Output values: `req_ready`=1, `busy`=0, and `start_div`, `rsp_valid`, `rsp_error` all 0.
  - `rsp_result`, `div_operand_a` and `div_operand_b` are 0.
- Special-case request accepted at T: `rsp_valid` at T+1. `start_div` never asserts.
- Normal request accepted at T: `start_div` at T+1. If `div_ready` is first seen at cycle W ≥ T+2, then `rsp_valid` is asserted at W+2.
- Next request can be accepted no earlier than the cycle after the response handshake.
- `req_valid` outside IDLE is ignored (`req_ready`=0).
- Reset mid-operation: IDLE on the next edge. Any in-flight divider result is discarded, and a `div_ready` arriving later in IDLE is ignored.

## Configuration
- `DIV_TIMEOUT_EN` defined:
  - A counter clears on entry to WAIT and increments on each WAIT cycle without `div_ready`.
  - After `TIMEOUT_CYCLES` such cycles, the next state is RESP with `rsp_result`=0 and `rsp_error`=1.
  - `rsp_error` clears on the next accepted request.
  - If `div_ready` and the limit coincide, `div_ready` wins.
- `DIV_TIMEOUT_EN` undefined: no counter; WAIT waits indefinitely; `rsp_error` tied 0.

## Test plan
- DIV -20 / 3, `div_ready` 5 cycles after `start_div` (divider returns q=6, r=2) -> `div_operand_a`=20, `div_operand_b`=3; `rsp_result`=0xFFFFFFFA exactly 2 cycles after `div_ready`.
- REM -20 / 3 -> 0xFFFFFFFE. REMU 0xFFFFFFEC / 3 -> divider receives raw operands, result 2.
- DIVU 7 / 0 -> `rsp_result`=0xFFFFFFFF at T+1, no `start_div`. REMU 7 / 0 -> 7.
- DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000, no `start_div`. REM of the same operands -> 0.
- `rsp_ready` low for 3 cycles -> `rsp_valid` and result held, `req_ready`=0, new `req_valid` ignored. Handshake -> IDLE next cycle.
- Watchdog and reset:
  - With `DIV_TIMEOUT_EN` and `TIMEOUT_CYCLES`=64, `div_ready` never asserted -> RESP after 64 WAIT cycles with `rsp_error`=1, result 0.
  - Reset asserted mid-WAIT -> IDLE, `busy`=0, `req_ready`=1 after the next edge.
